piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 130 +++++++++++++
 tb/tb_piso_serializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-entry holding register.
// Optional even-parity trailer bit per word: define PISO_PARITY_EN.
module piso_serializer #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ser_en,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_last,
  output logic [15:0]       words_sent
);

  localparam int CW = $clog2(DATA_W + 1);
`ifdef PISO_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [DATA_W-1:0] hold_data;
  logic              hold_full;
  logic              hold_full_n;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_n;
  logic [DATA_W-1:0] shreg_adv;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_n;
  logic              accept;
  logic              adv;
  logic              done;
  logic              load;
  logic              data_bit;
  logic              out_n;
  logic              last_n;
  logic              valid_n;

  assign in_ready = ~hold_full;
  assign accept   = in_valid & ~hold_full;
  assign adv      = (state == SHIFT) & ser_en;
  assign done     = adv & ser_last;
  assign load     = hold_full & ((state == IDLE) | done);

  assign shreg_adv = MSB_FIRST ? {shreg[DATA_W-2:0], 1'b0}
                               : {1'b0, shreg[DATA_W-1:1]};

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    cnt_n       = cnt;
    hold_full_n = hold_full | accept;
    if (load) begin
      state_n     = SHIFT;
      shreg_n     = hold_data;
      cnt_n       = '0;
      hold_full_n = accept;
    end else if (done) begin
      state_n = IDLE;
    end else if (adv) begin
      shreg_n = shreg_adv;
      cnt_n   = cnt + CW'(1);
    end
  end

  assign data_bit = MSB_FIRST ? shreg_n[DATA_W-1] : shreg_n[0];
  assign valid_n  = (state_n == SHIFT);
  assign last_n   = valid_n & (cnt_n == LAST);

`ifdef PISO_PARITY_EN
  logic par;
  logic par_n;

  assign par_n = load ? ^hold_data : par;
  // The slot after the last data bit carries the word's even parity.
  assign out_n = valid_n &
                 ((cnt_n == CW'(DATA_W)) ? par_n : data_bit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par <= 1'b0;
    end else begin
      par <= par_n;
    end
  end
`else
  assign out_n = valid_n & data_bit;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_data  <= '0;
      hold_full  <= 1'b0;
      shreg      <= '0;
      cnt        <= '0;
      ser_out    <= 1'b0;
      ser_valid  <= 1'b0;
      ser_last   <= 1'b0;
      words_sent <= '0;
    end else begin
      state     <= state_n;
      hold_full <= hold_full_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      ser_out   <= out_n;
      ser_valid <= valid_n;
      ser_last  <= last_n;
      if (accept) begin
        hold_data <= in_data;
      end
      if (done && (words_sent != 16'hFFFF)) begin
        words_sent <= words_sent + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: MSB-first and LSB-first instances share stimulus.
// Parity expectations follow PISO_PARITY_EN.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  typedef struct packed {
    logic [7:0] word;
    logic [7:0] m;
    logic [7:0] l;
    logic       par;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        ser_en;
  logic        m_in_ready, l_in_ready;
  logic        m_ser_out, l_ser_out;
  logic        m_ser_valid, l_ser_valid;
  logic        m_ser_last, l_ser_last;
  logic [15:0] m_words, l_words;

  int   total;
  int   passed;
  int   exp_words;
  vec_t tab [0:7];
  logic em    [0:17];
  logic el    [0:17];
  logic elast [0:17];

  piso_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .in_data(in_data),
    .in_valid(in_valid), .in_ready(m_in_ready),
    .ser_en(ser_en), .ser_out(m_ser_out),
    .ser_valid(m_ser_valid), .ser_last(m_ser_last),
    .words_sent(m_words)
  );

  piso_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_data(in_data),
    .in_valid(in_valid), .in_ready(l_in_ready),
    .ser_en(ser_en), .ser_out(l_ser_out),
    .ser_valid(l_ser_valid), .ser_last(l_ser_last),
    .words_sent(l_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_m_valid"}, m_ser_valid, 1'b0);
    chk({tag, "_l_valid"}, l_ser_valid, 1'b0);
    chk({tag, "_m_out"}, m_ser_out, 1'b0);
    chk({tag, "_l_out"}, l_ser_out, 1'b0);
    chk({tag, "_m_last"}, m_ser_last, 1'b0);
    chk({tag, "_l_last"}, l_ser_last, 1'b0);
    chk({tag, "_m_words"}, m_words, exp_words[15:0]);
    chk({tag, "_l_words"}, l_words, exp_words[15:0]);
  endtask

  task automatic clr();
    for (int k = 0; k < 18; k++) begin
      em[k]    = 1'b0;
      el[k]    = 1'b0;
      elast[k] = 1'b0;
    end
  endtask

  task automatic fill(input vec_t v, input int o);
    for (int k = 0; k < 8; k++) begin
      em[o+k] = v.m[7-k];
      el[o+k] = v.l[7-k];
    end
    if (NB == 9) begin
      em[o+NB-1] = v.par;
      el[o+NB-1] = v.par;
    end
    elast[o+NB-1] = 1'b1;
  endtask

  // Hand a word over while idle; returns with its first bit showing.
  task automatic start(input logic [7:0] w);
    for (int k = 0; k < 20 && !m_in_ready; k++) step();
    chk("start_ready", m_in_ready, 1'b1);
    in_data  = w;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("held_m_ready", m_in_ready, 1'b0);
    chk("held_l_ready", l_in_ready, 1'b0);
    chk("latency_valid", m_ser_valid, 1'b0);
    step();
  endtask

  task automatic play(input int n, input bit pend,
                      input logic [7:0] pw,
                      input int stall_at, input int stall_len,
                      input int words, input bit tail);
    for (int i = 0; i < n; i++) begin
      if (i == 0 && pend) begin
        chk("pend_ready", m_in_ready, 1'b1);
        in_data  = pw;
        in_valid = 1'b1;
      end
      chk($sformatf("m_valid%0d", i), m_ser_valid, 1'b1);
      chk($sformatf("l_valid%0d", i), l_ser_valid, 1'b1);
      chk($sformatf("m_bit%0d", i), m_ser_out, em[i]);
      chk($sformatf("l_bit%0d", i), l_ser_out, el[i]);
      chk($sformatf("m_last%0d", i), m_ser_last, elast[i]);
      chk($sformatf("l_last%0d", i), l_ser_last, elast[i]);
      if (i == stall_at) begin
        ser_en = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          step();
          chk($sformatf("stall_m_bit%0d", s), m_ser_out, em[i]);
          chk($sformatf("stall_l_bit%0d", s), l_ser_out, el[i]);
          chk($sformatf("stall_valid%0d", s), m_ser_valid, 1'b1);
          chk($sformatf("stall_last%0d", s), m_ser_last, elast[i]);
          chk($sformatf("stall_ready%0d", s), m_in_ready, !pend);
          chk($sformatf("stall_words%0d", s), m_words,
              exp_words[15:0]);
        end
        ser_en = 1'b1;
      end
      step();
      if (i == 0) in_valid = 1'b0;
    end
    if (tail) begin
      exp_words += words;
      chk_idle("tail");
      chk("tail_ready", m_in_ready, 1'b1);
    end
  endtask

  initial begin
    total     = 0;
    passed    = 0;
    exp_words = 0;
    tab[0] = '{8'hB0, 8'b10110000, 8'b00001101, 1'b1};
    tab[1] = '{8'h0D, 8'b00001101, 8'b10110000, 1'b1};
    tab[2] = '{8'hA5, 8'b10100101, 8'b10100101, 1'b0};
    tab[3] = '{8'h3C, 8'b00111100, 8'b00111100, 1'b0};
    tab[4] = '{8'h07, 8'b00000111, 8'b11100000, 1'b1};
    tab[5] = '{8'h03, 8'b00000011, 8'b11000000, 1'b0};
    tab[6] = '{8'hFF, 8'b11111111, 8'b11111111, 1'b0};
    tab[7] = '{8'h00, 8'b00000000, 8'b00000000, 1'b0};

    reset    = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    ser_en   = 1'b1;
    step();
    step();
    chk_idle("rst");
    chk("rst_m_ready", m_in_ready, 1'b1);
    chk("rst_l_ready", l_in_ready, 1'b1);
    reset = 1'b0;
    step();

    for (int t = 0; t < 8; t++) begin
      clr();
      fill(tab[t], 0);
      start(tab[t].word);
      play(NB, 1'b0, 8'h00, -1, 0, 1, 1'b1);
    end

    // back-to-back A5 then 3C, no gap
    clr();
    fill(tab[2], 0);
    fill(tab[3], NB);
    start(8'hA5);
    play(2*NB, 1'b1, 8'h3C, -1, 0, 2, 1'b1);

    // stall on second bit of B0 while 3C sits in the hold register
    clr();
    fill(tab[0], 0);
    fill(tab[3], NB);
    start(8'hB0);
    play(2*NB, 1'b1, 8'h3C, 1, 3, 2, 1'b1);

    // reset mid-word with a second word held
    clr();
    fill(tab[6], 0);
    start(8'hFF);
    play(4, 1'b1, 8'h3C, -1, 0, 0, 1'b0);
    chk("pre_rst_ready", m_in_ready, 1'b0);
    reset = 1'b1;
    #1;
    chk("async_ready", m_in_ready, 1'b1);
    chk("async_valid", m_ser_valid, 1'b0);
    exp_words = 0;
    step();
    chk_idle("midrst");
    chk("midrst_ready", l_in_ready, 1'b1);
    reset = 1'b0;
    step();
    chk_idle("post_rst");
    clr();
    fill(tab[0], 0);
    start(8'hB0);
    play(NB, 1'b0, 8'h00, -1, 0, 1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
